// File: rtl/acc_main_fsm.sv
// acc_main_fsm: layer sequencer behind the ICB register slave.
// Tiles a layer into och x ich passes and drives the DMA and compute array.
module acc_main_fsm #(
    parameter int unsigned OCH_TILE = 8,
    parameter int unsigned ICH_TILE = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] start,
    input  logic [31:0] in_addr,
    input  logic [31:0] w3_addr,
    input  logic [31:0] w1_addr,
    input  logic [31:0] out_addr,
    input  logic [31:0] mapsize,
    input  logic [31:0] ich,
    input  logic [31:0] och,
    output logic        dma_req_valid,
    input  logic        dma_req_ready,
    output logic        dma_req_wr,
    output logic [1:0]  dma_req_sel,
    output logic [31:0] dma_req_addr,
    output logic [31:0] dma_req_len,
    input  logic        dma_done,
    output logic        comp_start,
    output logic        comp_first,
    output logic        comp_last,
    output logic [3:0]  comp_och_cnt,
    output logic [3:0]  comp_ich_cnt,
    input  logic        comp_done,
    output logic        busy,
    output logic        acc_done
);

    typedef enum logic [3:0] {
        IDLE, SETUP, LD_W3, LD_W1, LD_IN,
        COMP, NXT_ICH, WB, NXT_OCH, FIN
    } state_e;

    // ENTRY: first cycle in state; REQ: request/kick outstanding; WAIT: await done
    typedef enum logic [1:0] {
        PH_ENTRY, PH_REQ, PH_WAIT
    } phase_e;

    state_e      state_q, state_d;
    phase_e      phase_q, phase_d;
    logic [31:0] in_addr_q, in_addr_d;
    logic [31:0] out_addr_q, out_addr_d;
    logic [31:0] w3_ptr_q, w3_ptr_d;
    logic [31:0] w1_ptr_q, w1_ptr_d;
    logic [31:0] area_q, area_d;
    logic [15:0] ich_q, ich_d;
    logic [15:0] och_q, och_d;
    logic [15:0] ich_idx_q, ich_idx_d;
    logic [15:0] och_idx_q, och_idx_d;

    logic [15:0] och_rem;
    logic [15:0] ich_rem;
    logic [3:0]  och_cnt;
    logic [3:0]  ich_cnt;
    logic [7:0]  tile_prod;
    logic [31:0] w3_len;
    logic [31:0] w1_len;
    logic [31:0] in_len;
    logic [31:0] wb_len;
    logic [31:0] in_off;
    logic [31:0] wb_off;
    logic        ich_last;
    logic        och_last;

    // Tile sizes, transfer lengths and offsets for the current pass
    always_comb begin
        och_rem   = och_q - och_idx_q;
        ich_rem   = ich_q - ich_idx_q;
        och_cnt   = (och_rem > 16'(OCH_TILE)) ? 4'(OCH_TILE) : och_rem[3:0];
        ich_cnt   = (ich_rem > 16'(ICH_TILE)) ? 4'(ICH_TILE) : ich_rem[3:0];
        tile_prod = 8'(och_cnt) * 8'(ich_cnt);
        w3_len    = 32'(tile_prod) * 32'd9;
        w1_len    = 32'(tile_prod);
        in_len    = 32'(ich_cnt) * area_q;
        wb_len    = 32'(och_cnt) * area_q;
        in_off    = 32'(ich_idx_q) * area_q;
        wb_off    = 32'(och_idx_q) * area_q;
        ich_last  = (17'(ich_idx_q) + 17'(ich_cnt)) >= 17'(ich_q);
        // decided on the och_idx of the tile just written back
        och_last  = (17'(och_idx_q) + 17'(OCH_TILE)) >= 17'(och_q);
    end

    // State, configuration and pointer registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            phase_q    <= PH_ENTRY;
            in_addr_q  <= '0;
            out_addr_q <= '0;
            w3_ptr_q   <= '0;
            w1_ptr_q   <= '0;
            area_q     <= '0;
            ich_q      <= '0;
            och_q      <= '0;
            ich_idx_q  <= '0;
            och_idx_q  <= '0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            in_addr_q  <= in_addr_d;
            out_addr_q <= out_addr_d;
            w3_ptr_q   <= w3_ptr_d;
            w1_ptr_q   <= w1_ptr_d;
            area_q     <= area_d;
            ich_q      <= ich_d;
            och_q      <= och_d;
            ich_idx_q  <= ich_idx_d;
            och_idx_q  <= och_idx_d;
        end
    end

    // Next-state, tile walk and pointer advance
    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        in_addr_d  = in_addr_q;
        out_addr_d = out_addr_q;
        w3_ptr_d   = w3_ptr_q;
        w1_ptr_d   = w1_ptr_q;
        area_d     = area_q;
        ich_d      = ich_q;
        och_d      = och_q;
        ich_idx_d  = ich_idx_q;
        och_idx_d  = och_idx_q;
        unique case (state_q)
            IDLE: begin
                phase_d = PH_ENTRY;
                if (start[0]) state_d = SETUP;
            end
            SETUP: begin
                in_addr_d  = in_addr;
                out_addr_d = out_addr;
                w3_ptr_d   = w3_addr;
                w1_ptr_d   = w1_addr;
                area_d     = 32'(mapsize[15:0]) * 32'(mapsize[15:0]);
                ich_d      = ich[15:0];
                och_d      = och[15:0];
                ich_idx_d  = '0;
                och_idx_d  = '0;
                phase_d    = PH_ENTRY;
                if (mapsize[15:0] == 16'd0 || ich[15:0] == 16'd0 ||
                    och[15:0] == 16'd0) begin
                    state_d = FIN;
                end else begin
                    state_d = LD_W3;
                end
            end
            LD_W3, LD_W1, LD_IN, WB: begin
                unique case (phase_q)
                    PH_ENTRY: phase_d = PH_REQ;
                    PH_REQ: if (dma_req_ready) phase_d = PH_WAIT;
                    PH_WAIT: begin
                        if (dma_done) begin
                            phase_d = PH_ENTRY;
                            unique case (state_q)
                                LD_W3: begin
                                    w3_ptr_d = w3_ptr_q + w3_len;
                                    state_d  = LD_W1;
                                end
                                LD_W1: begin
                                    w1_ptr_d = w1_ptr_q + w1_len;
                                    state_d  = LD_IN;
                                end
                                LD_IN:   state_d = COMP;
                                default: state_d = NXT_OCH;
                            endcase
                        end
                    end
                    default: phase_d = PH_ENTRY;
                endcase
            end
            COMP: begin
                if (phase_q == PH_ENTRY) begin
                    phase_d = PH_WAIT;
                end else if (comp_done) begin
                    phase_d = PH_ENTRY;
                    state_d = ich_last ? WB : NXT_ICH;
                end
            end
            NXT_ICH: begin
                ich_idx_d = ich_idx_q + 16'(ICH_TILE);
                phase_d   = PH_ENTRY;
                state_d   = LD_W3;
            end
            NXT_OCH: begin
                och_idx_d = och_idx_q + 16'(OCH_TILE);
                ich_idx_d = '0;
                phase_d   = PH_ENTRY;
                state_d   = och_last ? FIN : LD_W3;
            end
            FIN: begin
                phase_d = PH_ENTRY;
                state_d = IDLE;
            end
            default: begin
                phase_d = PH_ENTRY;
                state_d = IDLE;
            end
        endcase
    end

    // Moore outputs: DMA request fields, compute kick, status
    always_comb begin
        dma_req_valid = 1'b0;
        dma_req_wr    = 1'b0;
        dma_req_sel   = 2'd0;
        dma_req_addr  = '0;
        dma_req_len   = '0;
        comp_start    = 1'b0;
        comp_first    = 1'b0;
        comp_last     = 1'b0;
        comp_och_cnt  = '0;
        comp_ich_cnt  = '0;
        busy          = (state_q != IDLE);
        acc_done      = 1'b0;
        unique case (state_q)
            LD_W3: begin
                dma_req_valid = (phase_q == PH_REQ);
                dma_req_sel   = 2'd0;
                dma_req_addr  = w3_ptr_q;
                dma_req_len   = w3_len;
            end
            LD_W1: begin
                dma_req_valid = (phase_q == PH_REQ);
                dma_req_sel   = 2'd1;
                dma_req_addr  = w1_ptr_q;
                dma_req_len   = w1_len;
            end
            LD_IN: begin
                dma_req_valid = (phase_q == PH_REQ);
                dma_req_sel   = 2'd2;
                dma_req_addr  = in_addr_q + in_off;
                dma_req_len   = in_len;
            end
            WB: begin
                dma_req_valid = (phase_q == PH_REQ);
                dma_req_wr    = 1'b1;
                dma_req_sel   = 2'd3;
                dma_req_addr  = out_addr_q + wb_off;
                dma_req_len   = wb_len;
            end
            COMP: begin
                comp_start   = (phase_q == PH_ENTRY);
                comp_first   = comp_start && (ich_idx_q == 16'd0);
                comp_last    = comp_start && ich_last;
                comp_och_cnt = och_cnt;
                comp_ich_cnt = ich_cnt;
            end
            FIN: acc_done = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_acc_main_fsm.sv
// tb_acc_main_fsm: directed bench for the layer sequencer.
// Plays DMA and compute engines by hand and checks every request.
module tb_acc_main_fsm;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] start;
    logic [31:0] in_addr;
    logic [31:0] w3_addr;
    logic [31:0] w1_addr;
    logic [31:0] out_addr;
    logic [31:0] mapsize;
    logic [31:0] ich;
    logic [31:0] och;
    logic        dma_req_valid;
    logic        dma_req_ready;
    logic        dma_req_wr;
    logic [1:0]  dma_req_sel;
    logic [31:0] dma_req_addr;
    logic [31:0] dma_req_len;
    logic        dma_done;
    logic        comp_start;
    logic        comp_first;
    logic        comp_last;
    logic [3:0]  comp_och_cnt;
    logic [3:0]  comp_ich_cnt;
    logic        comp_done;
    logic        busy;
    logic        acc_done;

    int vectors = 0;
    int errors  = 0;
    int acc_cnt = 0;
    int req_cnt = 0;
    int kick_cnt = 0;
    int snap_acc;
    int snap_req;
    int snap_kick;

    always #5 clk = ~clk;

    acc_main_fsm dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .in_addr       (in_addr),
        .w3_addr       (w3_addr),
        .w1_addr       (w1_addr),
        .out_addr      (out_addr),
        .mapsize       (mapsize),
        .ich           (ich),
        .och           (och),
        .dma_req_valid (dma_req_valid),
        .dma_req_ready (dma_req_ready),
        .dma_req_wr    (dma_req_wr),
        .dma_req_sel   (dma_req_sel),
        .dma_req_addr  (dma_req_addr),
        .dma_req_len   (dma_req_len),
        .dma_done      (dma_done),
        .comp_start    (comp_start),
        .comp_first    (comp_first),
        .comp_last     (comp_last),
        .comp_och_cnt  (comp_och_cnt),
        .comp_ich_cnt  (comp_ich_cnt),
        .comp_done     (comp_done),
        .busy          (busy),
        .acc_done      (acc_done)
    );

    // Event counters for pulse-count checks
    always @(posedge clk) begin
        if (acc_done)      acc_cnt  <= acc_cnt + 1;
        if (dma_req_valid) req_cnt  <= req_cnt + 1;
        if (comp_start)    kick_cnt <= kick_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic launch(input logic [31:0] ms, input logic [31:0] ic,
                          input logic [31:0] oc);
        mapsize = ms;
        ich     = ic;
        och     = oc;
        start   = 32'd1;
        @(negedge clk);
        start   = 32'd0;
    endtask

    task automatic wait_valid();
        int n;
        n = 0;
        while (dma_req_valid !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic expect_dma(input string tag, input logic wr,
                              input logic [1:0] sel, input logic [31:0] addr,
                              input logic [31:0] len);
        wait_valid();
        check({tag, "_valid"}, 32'(dma_req_valid), 32'd1);
        check({tag, "_wr"}, 32'(dma_req_wr), 32'(wr));
        check({tag, "_sel"}, 32'(dma_req_sel), 32'(sel));
        check({tag, "_addr"}, dma_req_addr, addr);
        check({tag, "_len"}, dma_req_len, len);
        dma_req_ready = 1'b1;
        @(negedge clk);
        dma_req_ready = 1'b0;
        check({tag, "_drop"}, 32'(dma_req_valid), 32'd0);
        repeat (2) @(negedge clk);
        dma_done = 1'b1;
        @(negedge clk);
        dma_done = 1'b0;
    endtask

    task automatic expect_comp(input string tag, input logic first,
                               input logic last, input logic [3:0] oc,
                               input logic [3:0] ic, input logic do_done);
        int n;
        n = 0;
        while (comp_start !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_kick"}, 32'(comp_start), 32'd1);
        check({tag, "_first"}, 32'(comp_first), 32'(first));
        check({tag, "_last"}, 32'(comp_last), 32'(last));
        check({tag, "_och"}, 32'(comp_och_cnt), 32'(oc));
        check({tag, "_ich"}, 32'(comp_ich_cnt), 32'(ic));
        @(negedge clk);
        check({tag, "_kick_drop"}, 32'(comp_start), 32'd0);
        check({tag, "_ich_hold"}, 32'(comp_ich_cnt), 32'(ic));
        if (do_done) begin
            repeat (2) @(negedge clk);
            comp_done = 1'b1;
            @(negedge clk);
            comp_done = 1'b0;
        end
    endtask

    task automatic expect_done(input string tag);
        int n;
        n = 0;
        while (acc_done !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_acc"}, 32'(acc_done), 32'd1);
        check({tag, "_busy_fin"}, 32'(busy), 32'd1);
        @(negedge clk);
        check({tag, "_acc_drop"}, 32'(acc_done), 32'd0);
        check({tag, "_busy_drop"}, 32'(busy), 32'd0);
    endtask

    task automatic run_s1(input string tag);
        launch(32'd4, 32'd8, 32'd8);
        expect_dma({tag, "_w3"}, 1'b0, 2'd0, 32'h2000, 32'd576);
        expect_dma({tag, "_w1"}, 1'b0, 2'd1, 32'h3000, 32'd64);
        expect_dma({tag, "_in"}, 1'b0, 2'd2, 32'h1000, 32'd128);
        expect_comp({tag, "_c"}, 1'b1, 1'b1, 4'd8, 4'd8, 1'b1);
        expect_dma({tag, "_wb"}, 1'b1, 2'd3, 32'h4000, 32'd128);
        expect_done(tag);
    endtask

    initial begin
        rst_n         = 1'b0;
        start         = '0;
        in_addr       = 32'h1000;
        w3_addr       = 32'h2000;
        w1_addr       = 32'h3000;
        out_addr      = 32'h4000;
        mapsize       = '0;
        ich           = '0;
        och           = '0;
        dma_req_ready = 1'b0;
        dma_done      = 1'b0;
        comp_done     = 1'b0;

        // reset state
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_valid", 32'(dma_req_valid), 32'd0);
        check("rst_addr", dma_req_addr, 32'd0);
        check("rst_len", dma_req_len, 32'd0);
        check("rst_kick", 32'(comp_start), 32'd0);
        check("rst_acc", 32'(acc_done), 32'd0);
        rst_n = 1'b1;

        // stray engine pulses while idle
        dma_done  = 1'b1;
        comp_done = 1'b1;
        @(negedge clk);
        dma_done  = 1'b0;
        comp_done = 1'b0;
        @(negedge clk);
        check("idle_stray_busy", 32'(busy), 32'd0);

        // single-pass layer
        snap_acc = acc_cnt;
        run_s1("s1");
        check("s1_acc_cnt", 32'(acc_cnt - snap_acc), 32'd1);

        // 2 x 2 tiles with partial tiles, stray comp_done in LD_W3
        snap_acc = acc_cnt;
        launch(32'd4, 32'd12, 32'd10);
        @(negedge clk);
        comp_done = 1'b1;
        @(negedge clk);
        comp_done = 1'b0;
        expect_dma("s2a_w3", 1'b0, 2'd0, 32'h2000, 32'd576);
        expect_dma("s2a_w1", 1'b0, 2'd1, 32'h3000, 32'd64);
        expect_dma("s2a_in", 1'b0, 2'd2, 32'h1000, 32'd128);
        expect_comp("s2a_c", 1'b1, 1'b0, 4'd8, 4'd8, 1'b1);
        expect_dma("s2b_w3", 1'b0, 2'd0, 32'h2240, 32'd288);
        expect_dma("s2b_w1", 1'b0, 2'd1, 32'h3040, 32'd32);
        expect_dma("s2b_in", 1'b0, 2'd2, 32'h1080, 32'd64);
        expect_comp("s2b_c", 1'b0, 1'b1, 4'd8, 4'd4, 1'b1);
        expect_dma("s2b_wb", 1'b1, 2'd3, 32'h4000, 32'd128);
        expect_dma("s2c_w3", 1'b0, 2'd0, 32'h2360, 32'd144);
        expect_dma("s2c_w1", 1'b0, 2'd1, 32'h3060, 32'd16);
        expect_dma("s2c_in", 1'b0, 2'd2, 32'h1000, 32'd128);
        expect_comp("s2c_c", 1'b1, 1'b0, 4'd2, 4'd8, 1'b1);
        expect_dma("s2d_w3", 1'b0, 2'd0, 32'h23f0, 32'd72);
        expect_dma("s2d_w1", 1'b0, 2'd1, 32'h3070, 32'd8);
        expect_dma("s2d_in", 1'b0, 2'd2, 32'h1080, 32'd64);
        expect_comp("s2d_c", 1'b0, 1'b1, 4'd2, 4'd4, 1'b1);
        expect_dma("s2d_wb", 1'b1, 2'd3, 32'h4080, 32'd32);
        expect_done("s2");
        check("s2_acc_cnt", 32'(acc_cnt - snap_acc), 32'd1);

        // och = 0: SETUP then FIN, no engine activity
        snap_req  = req_cnt;
        snap_kick = kick_cnt;
        launch(32'd4, 32'd8, 32'd0);
        check("z_setup_busy", 32'(busy), 32'd1);
        check("z_setup_acc", 32'(acc_done), 32'd0);
        @(negedge clk);
        check("z_fin_acc", 32'(acc_done), 32'd1);
        @(negedge clk);
        check("z_idle_acc", 32'(acc_done), 32'd0);
        check("z_idle_busy", 32'(busy), 32'd0);
        check("z_no_req", 32'(req_cnt - snap_req), 32'd0);
        check("z_no_kick", 32'(kick_cnt - snap_kick), 32'd0);

        // LD_W1 stall with stray done, start held high while busy
        snap_acc = acc_cnt;
        launch(32'd4, 32'd8, 32'd8);
        start = 32'd1;
        expect_dma("st_w3", 1'b0, 2'd0, 32'h2000, 32'd576);
        wait_valid();
        check("st_w1_sel", 32'(dma_req_sel), 32'd1);
        for (int i = 0; i < 5; i++) begin
            dma_done = (i == 2);
            @(negedge clk);
            check("st_valid", 32'(dma_req_valid), 32'd1);
            check("st_addr", dma_req_addr, 32'h3000);
            check("st_len", dma_req_len, 32'd64);
        end
        dma_done      = 1'b0;
        dma_req_ready = 1'b1;
        @(negedge clk);
        dma_req_ready = 1'b0;
        check("st_drop", 32'(dma_req_valid), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("st_hold", 32'(dma_req_valid), 32'd0);
        end
        dma_done = 1'b1;
        @(negedge clk);
        dma_done = 1'b0;
        expect_dma("st_in", 1'b0, 2'd2, 32'h1000, 32'd128);
        expect_comp("st_c", 1'b1, 1'b1, 4'd8, 4'd8, 1'b1);
        start = 32'd0;
        expect_dma("st_wb", 1'b1, 2'd3, 32'h4000, 32'd128);
        expect_done("st");
        repeat (3) @(negedge clk);
        check("st_acc_cnt", 32'(acc_cnt - snap_acc), 32'd1);
        check("st_idle_busy", 32'(busy), 32'd0);

        // reset during COMP aborts, then a clean rerun
        launch(32'd4, 32'd8, 32'd8);
        expect_dma("ra_w3", 1'b0, 2'd0, 32'h2000, 32'd576);
        expect_dma("ra_w1", 1'b0, 2'd1, 32'h3000, 32'd64);
        expect_dma("ra_in", 1'b0, 2'd2, 32'h1000, 32'd128);
        expect_comp("ra_c", 1'b1, 1'b1, 4'd8, 4'd8, 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("ra_busy", 32'(busy), 32'd0);
        check("ra_valid", 32'(dma_req_valid), 32'd0);
        check("ra_kick", 32'(comp_start), 32'd0);
        check("ra_och_cnt", 32'(comp_och_cnt), 32'd0);
        check("ra_acc", 32'(acc_done), 32'd0);
        repeat (3) @(negedge clk);
        check("ra_stay_idle", 32'(busy), 32'd0);
        run_s1("rr");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
